// File: rtl/trans_energy_accum_if.sv
// Snapshot/result bus of trans_energy_accum. The master drives events and
// snapshot requests and consumes the result; the slave is the accumulator.
interface trans_energy_accum_if #(
  parameter int ACC_W = 27
) ();
  logic [5:0]       ev;
  logic             snap;
  logic             busy;
  logic [ACC_W-1:0] res;
  // res/res_valid hold steady while res_valid=1; a transfer happens on any
  // rising clock edge that samples res_valid=1 and res_ready=1 together.
  logic             res_valid;
  logic             res_ready;
  logic             ovf;

  modport master (
    output ev, snap, res_ready,
    input  busy, res, res_valid, ovf
  );

  modport slave (
    input  ev, snap, res_ready,
    output busy, res, res_valid, ovf
  );
endinterface

// File: rtl/trans_energy_accum.sv
// Per-class toggle counters with a serial weighted-energy snapshot engine.
// Define TRANS_CNT_SAT_EN for saturating counters and a sticky ovf flag.
module trans_energy_accum #(
  parameter int CNT_W   = 16,
  parameter int WGT_W   = 8,
  parameter int ACC_W   = 27,
  parameter int W_BUF   = 10,
  parameter int W_INV   = 7,
  parameter int W_NAND  = 7,
  parameter int W_NOR   = 10,
  parameter int W_DFF   = 12,
  parameter int W_DFFSR = 12
) (
  input  logic                  C,
  input  logic                  R,
  trans_energy_accum_if.slave   bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [CNT_W-1:0] cnt_inc [6];
  logic [CNT_W-1:0] shd_q [6];
  logic [CNT_W-1:0] shd_d [6];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] term;
  logic [CNT_W-1:0] sel_cnt;
  logic [WGT_W-1:0] sel_w;
  logic [2:0]       k_q, k_d;
  logic             vld_q, vld_d;

`ifdef TRANS_CNT_SAT_EN
  logic ev_at_max;
  logic ovf_q;

  always_comb begin
    ev_at_max = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (bus.ev[i]) begin
        if (&cnt_q[i]) ev_at_max = 1'b1;
        else           cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge C) begin
    if (R)              ovf_q <= 1'b0;
    else if (ev_at_max) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      cnt_inc[i] = bus.ev[i] ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end

  assign bus.ovf = 1'b0;
`endif

  // One class per ACCUM cycle: shadow count of class k times its weight.
  always_comb begin
    sel_cnt = '0;
    sel_w   = '0;
    case (k_q)
      3'd0: begin sel_cnt = shd_q[0]; sel_w = WGT_W'(W_BUF);   end
      3'd1: begin sel_cnt = shd_q[1]; sel_w = WGT_W'(W_INV);   end
      3'd2: begin sel_cnt = shd_q[2]; sel_w = WGT_W'(W_NAND);  end
      3'd3: begin sel_cnt = shd_q[3]; sel_w = WGT_W'(W_NOR);   end
      3'd4: begin sel_cnt = shd_q[4]; sel_w = WGT_W'(W_DFF);   end
      3'd5: begin sel_cnt = shd_q[5]; sel_w = WGT_W'(W_DFFSR); end
      default: ;
    endcase
    term = ACC_W'(sel_cnt) * ACC_W'(sel_w);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    shd_d   = shd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    k_d     = k_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (bus.snap) begin
          shd_d = cnt_inc;
          for (int i = 0; i < 6; i++) cnt_d[i] = '0;
          acc_d   = '0;
          k_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd5) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle publishes the sum; afterwards wait for the consumer.
        if (!vld_q) begin
          vld_d = 1'b1;
          res_d = acc_q;
        end else if (bus.res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
      acc_q <= '0;
      res_q <= '0;
      k_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
        shd_q[i] <= shd_d[i];
      end
      acc_q <= acc_d;
      res_q <= res_d;
      k_q   <= k_d;
      vld_q <= vld_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.res       = res_q;
  assign bus.res_valid = vld_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/trans_energy_accum.md
Name: trans_energy_accum

Overview:
- Synthesizable downstream consumer of per-cell-class transition events produced by the CMOS cell library: BUF, NOT, NAND, NOR, DFF and DFFSR output toggles.
- Counts toggles per class over a measurement window. On a snapshot request, computes weighted switching energy E = sum(count_i * W_i) serially, one class per cycle.
- Delivers E over a valid/ready handshake to the power-report logic.
- Replaces the testbench-only counter array with hardware counters usable in emulation.

Parameters:
- CNT_W, 16: width of each per-class toggle counter.
- WGT_W, 8: width of each per-class energy weight.
- ACC_W, 27: result width; must be >= CNT_W+WGT_W+3.
- W_BUF, 10: energy units per BUF toggle.
- W_INV, 7: energy units per NOT toggle.
- W_NAND, 7: energy units per NAND toggle.
- W_NOR, 10: energy units per NOR toggle.
- W_DFF, 12: energy units per DFF toggle.
- W_DFFSR, 12: energy units per DFFSR toggle.

Ports:
- C, input, 1: clock, rising edge.
- R, input, 1: reset, synchronous, active-high.
- ev, input, 6: per-class toggle strobe, one event per set bit per cycle. Bit order: 0 BUF, 1 INV, 2 NAND, 3 NOR, 4 DFF, 5 DFFSR.
- snap, input, 1: snapshot request, single-cycle pulse.
- busy, output, 1: high while not IDLE.
- res, output, ACC_W: weighted energy of the last snapshot window.
- res_valid, output, 1: res valid.
- res_ready, input, 1: consumer accepts res.
- ovf, output, 1: sticky counter overflow flag (see Optional Feature).

Behaviour:
- Reset (R=1 at a rising edge C):
  - All six live counters, shadow counters and the accumulator go to 0.
  - res=0, res_valid=0, busy=0, ovf=0, FSM=IDLE.
  - Reset mid-operation aborts any computation, with no partial result.
- Live counters:
  - Each counter increments by 1 on every cycle its ev bit is 1. All six can increment in the same cycle.
  - Counters count in every FSM state.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - snap=1 latches all six live counters into shadow counters, including any ev seen in the same cycle.
  - In the same cycle, live counters load 0 and the accumulator clears.
  - Next state is ACCUM with index k=0.
- ACCUM:
  - Each cycle: acc <= acc + shadow[k]*W_k, computed at width ACC_W with zero-extended operands; then k <= k+1.
  - After k=5, next state is DONE. ACCUM lasts exactly 6 cycles.
- DONE:
  - res=acc and res_valid=1. Both hold stable until res_ready=1 is sampled.
  - On acceptance: res_valid=0 next cycle, return to IDLE. res keeps its last value.
  - res_ready is ignored when res_valid=0.
- Latency: snap sampled at edge t gives res_valid=1 after edge t+7. A res_ready held at 1 returns to IDLE after edge t+8.
- busy=1 in ACCUM and DONE.
- snap in ACCUM or DONE is ignored and dropped. Live counters are not cleared and keep counting.
- snap and R in the same cycle: R wins.
- The accumulator cannot overflow given ACC_W >= CNT_W+WGT_W+3.

Optional Feature:
- Macro: TRANS_CNT_SAT_EN.
- Defined:
  - A live counter at all-ones stays at all-ones on further events.
  - ovf is set sticky on any event arriving while a counter is at all-ones.
  - ovf clears only on R; snap does not clear it.
- Undefined:
  - Counters wrap modulo 2^CNT_W.
  - ovf is tied to 0.

Test Plan:
- Reset/idle: assert R for 2 cycles with ev=6'h3F, then release -> res=0, res_valid=0, busy=0, ovf=0. With R low, ev=6'h3F for 3 cycles plus snap -> res = 4*(10+7+7+10+12+12) = 232.
- Weighted sum: ev[0] for 5 cycles, ev[4] for 3 cycles, then snap with ev=0 -> res = 5*10+3*12 = 86, res_valid asserted exactly 7 cycles after snap.
- Back-pressure: hold res_ready=0 for 10 cycles after res_valid -> res stable and busy=1. A snap pulse during the hold is dropped. ev[1] for 4 cycles during the hold, then release ready, then snap -> second res=28.
- Window boundary: ev[3]=1 in the same cycle as snap, after 2 prior ev[3] cycles -> first res=30. Live counter starts at 0, so a following snap with no events gives res=0.
- Reset mid-ACCUM: R in the 3rd ACCUM cycle -> no res_valid, counters 0. A subsequent snap after 0 events gives res=0.
- Overflow (CNT_W=4): 20 ev[2] events, then snap. With TRANS_CNT_SAT_EN: res=15*7=105 and ovf=1. Without it: res=4*7=28 and ovf=0.
